// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM encoding, frame width and
// baud divisor helper.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

    function automatic int unsigned baud_ticks(input int unsigned clk_freq,
                                               input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus falling-edge detect.
// All flops reset high so a line that idles high produces no edge out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, with valid/ready output and one-cycle
// frame-error and overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int unsigned BaudTicks = baud_ticks(CLK_FREQ, BAUD_RATE);
    localparam int unsigned Half      = BaudTicks / 2;
    localparam logic [15:0] TickLast  = 16'(BaudTicks - 1);
    localparam logic [15:0] HalfLast  = 16'(Half - 1);
    localparam logic [2:0]  BitLast   = 3'(DATA_BITS - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    rx_state_e            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 overrun_q, overrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d   = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (cnt_q == TickLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == BitLast) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (cnt_q == TickLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        // Consumed in this same cycle means no byte was lost.
                        overrun_d  = rx_valid_q && !rx_ready;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q != StIdle);
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
8N1 UART receiver, LSB first. It is the receive-side counterpart of the team's UART transmitter and shares the same CLK_FREQ/BAUD_RATE parameterisation.
- Synchronises the asynchronous rx line and validates the start bit at mid-bit.
- Samples each data and stop bit at its centre.
- Presents received bytes on a valid/ready output with framing-error and overrun reporting.
- Sits between the board UART pin and the frame-processing logic.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in bits/s. BAUD_TICKS = CLK_FREQ/BAUD_RATE must be < 65536 and >= 4.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
rx  input  1  serial line, asynchronous, idle high.
rx_data  output  8  last received byte.
rx_valid  output  1  rx_data holds an unconsumed byte.
rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
busy  output  1  high while the FSM is not IDLE.
frame_error  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: a byte completed while the previous byte was unconsumed.

Behaviour:
Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Reset values:
- rx_data=0, rx_valid=0, busy=0, frame_error=0, overrun=0.
- Synchroniser flops and previous-sample register = 1; FSM = IDLE; counters = 0.
- Reset asserted mid-frame aborts the frame; no partial byte is ever delivered.

Front end:
- 2-FF synchroniser on rx gives rx_s.
- Registered rx_prev detects the falling edge (rx_prev=1, rx_s=0).

Constants: HALF = BAUD_TICKS/2 (floor). 16-bit baud counter, 3-bit bit index.

FSM:
- IDLE: busy=0. On falling edge go to START, counter=0.
- START: count up. At counter==HALF-1 sample rx_s.
  - rx_s==0: go to DATA, counter=0, bit index=0.
  - rx_s==1 (glitch): go to IDLE, no output.
- DATA: at counter==BAUD_TICKS-1, shift rx_s into the shift register MSB (shift right), counter=0.
  - After bit index 7 goes to STOP; otherwise increment bit index.
- STOP: at counter==BAUD_TICKS-1 sample rx_s, then go to IDLE (about mid stop bit, for resync margin).
  - rx_s==1: load rx_data from the shift register, set rx_valid.
  - rx_s==0: pulse frame_error, discard the byte; rx_data and rx_valid are unchanged.
- busy=1 in START, DATA and STOP.

Break / line held low: IDLE requires a new 1->0 edge, so a held-low line never retriggers.

Handshake:
- rx_valid stays high until the cycle in which rx_ready=1, then clears next cycle.
- rx_data is stable while rx_valid=1, except on overrun.

Simultaneous events:
- Completion with rx_valid=1 and rx_ready=0: overwrite rx_data, keep rx_valid=1, pulse overrun.
- Completion with rx_valid=1 and rx_ready=1 in the same cycle: load the new byte, rx_valid stays 1, no overrun.
- rx_ready with rx_valid=0 is ignored.

Latency: rx_valid rises 3 + HALF + 9*BAUD_TICKS clocks (±1) after the start-bit falling edge at the pin.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE/START/DATA/STOP (2-bit);
  - a baud_ticks(clk_freq, baud) constant function;
  - DATA_BITS=8.
- One sub-module, uart_rx_sync: 2-FF synchroniser plus falling-edge detect.
  - Outputs rx_s and fall.
  - Reset to 1 on rst_n low.

Test Plan:
All cases use CLK_FREQ=1000000, BAUD_RATE=100000, so BAUD_TICKS=10 and HALF=5.
1. Valid frame 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5, frame_error never pulses; rx_valid held until rx_ready pulses, then 0 the next cycle.
2. rx low for 3 clocks, then high -> busy rises then falls about 6 clocks later; rx_valid=0, frame_error=0.
3. Frame 0x3C with stop bit driven 0, line held low 40 clocks, then high -> exactly one frame_error pulse, rx_valid stays 0, busy=0 throughout the low hold; the next valid frame 0x3C is received.
4. Back-to-back 0x11 then 0x22, rx_ready=0 -> rx_data=0x11, then overrun pulse, rx_data=0x22, rx_valid=1. Repeat with rx_ready=1 in the completion cycle -> no overrun.
5. rst_n low during bit 4 of 0x5A -> all outputs 0 immediately; after release, frame 0x5A is received correctly with no spurious rx_valid.
6. Loopback from the team's UART transmitter (same parameters), bytes 0x00..0xFF with rx_ready tied 1 -> 256 rx_valid pulses matching in order, no frame_error, no overrun.
